// File: rtl/conv3x3_mac.sv
// 3x3 signed fixed-point convolution MAC with shadow/active weight banks,
// three-stage multiply / sum / round-saturate pipeline and a line counter.
module conv3x3_mac #(
  parameter int INTEGER_BITS     = 9,
  parameter int FIXED_POINT_BITS = 4,
  localparam int W               = INTEGER_BITS + FIXED_POINT_BITS
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [9*W-1:0]   i_pixel_data,
  input  logic             i_pixel_data_valid,
  input  logic [W-1:0]     i_wt_data,
  input  logic             i_wt_valid,
  input  logic             i_relu_en,
  output logic [W-1:0]     o_conv_data,
  output logic             o_conv_data_valid,
  output logic             o_wt_loaded,
  output logic             o_line_done
);

  localparam int SW = 2*W + 4;
  localparam logic signed [SW-1:0] SAT_MAX = SW'(2**(W-1) - 1);
  localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;

  logic signed [W-1:0]    r_shadow [9];
  logic signed [W-1:0]    r_active [9];
  logic [3:0]             r_wt_idx;
  logic                   r_wt_loaded;

  logic signed [2*W-1:0]  r_prod [9];
  logic                   r_s1_valid;
  logic                   r_s1_relu;
  logic signed [SW-1:0]   r_sum;
  logic                   r_s2_valid;
  logic                   r_s2_relu;
  logic [W-1:0]           r_conv_data;
  logic                   r_conv_valid;
  logic [8:0]             r_out_cnt;
  logic                   r_line_done;

  logic signed [SW-1:0]   w_sum;
  logic signed [SW-1:0]   w_shift;
  logic signed [W-1:0]    w_res;

  // The commit on the 9th write uses the incoming word directly so the
  // whole set lands in the active bank at the same edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wt_idx    <= '0;
      r_wt_loaded <= 1'b0;
      for (int k = 0; k < 9; k++) begin
        r_shadow[k] <= '0;
        r_active[k] <= '0;
      end
    end else if (i_wt_valid) begin
      r_shadow[r_wt_idx] <= i_wt_data;
      if (r_wt_idx == 4'd8) begin
        r_wt_idx    <= '0;
        r_wt_loaded <= 1'b1;
        for (int k = 0; k < 8; k++)
          r_active[k] <= r_shadow[k];
        r_active[8] <= i_wt_data;
      end else begin
        r_wt_idx <= r_wt_idx + 4'd1;
      end
    end
  end

  always_comb begin
    w_sum = '0;
    for (int k = 0; k < 9; k++)
      w_sum = w_sum + {{4{r_prod[k][2*W-1]}}, r_prod[k]};
  end

  assign w_shift = r_sum >>> FIXED_POINT_BITS;

  always_comb begin
    w_res = w_shift[W-1:0];
    if (r_s2_relu && w_shift[SW-1])
      w_res = '0;
    else if (w_shift > SAT_MAX)
      w_res = SAT_MAX[W-1:0];
    else if (w_shift < SAT_MIN)
      w_res = SAT_MIN[W-1:0];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < 9; k++)
        r_prod[k] <= '0;
      r_s1_valid   <= 1'b0;
      r_s1_relu    <= 1'b0;
      r_sum        <= '0;
      r_s2_valid   <= 1'b0;
      r_s2_relu    <= 1'b0;
      r_conv_data  <= '0;
      r_conv_valid <= 1'b0;
      r_out_cnt    <= '0;
      r_line_done  <= 1'b0;
    end else begin
      r_s1_valid <= i_pixel_data_valid;
      if (i_pixel_data_valid) begin
        r_s1_relu <= i_relu_en;
        for (int k = 0; k < 9; k++)
          r_prod[k] <= $signed(i_pixel_data[W*k +: W]) * r_active[k];
      end
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_sum     <= w_sum;
        r_s2_relu <= r_s1_relu;
      end
      r_conv_valid <= r_s2_valid;
      if (r_s2_valid)
        r_conv_data <= w_res;
      if (r_conv_valid)
        r_out_cnt <= r_out_cnt + 9'd1;
      r_line_done <= r_conv_valid && (&r_out_cnt);
    end
  end

  assign o_conv_data       = r_conv_data;
  assign o_conv_data_valid = r_conv_valid;
  assign o_wt_loaded       = r_wt_loaded;
  assign o_line_done       = r_line_done;

endmodule

// File: tb/tb_conv3x3_mac.sv
// Randomized bench for conv3x3_mac against an integer-arithmetic
// reference model with a 3-deep expected-output delay line.
module tb_conv3x3_mac;

  localparam int W = 13;

  logic           clk = 1'b0;
  logic           i_rst;
  logic [9*W-1:0] i_pixel_data;
  logic           i_pixel_data_valid;
  logic [W-1:0]   i_wt_data;
  logic           i_wt_valid;
  logic           i_relu_en;
  logic [W-1:0]   o_conv_data;
  logic           o_conv_data_valid;
  logic           o_wt_loaded;
  logic           o_line_done;

  always #5 clk = ~clk;

  conv3x3_mac dut (
    .i_clk              (clk),
    .i_rst              (i_rst),
    .i_pixel_data       (i_pixel_data),
    .i_pixel_data_valid (i_pixel_data_valid),
    .i_wt_data          (i_wt_data),
    .i_wt_valid         (i_wt_valid),
    .i_relu_en          (i_relu_en),
    .o_conv_data        (o_conv_data),
    .o_conv_data_valid  (o_conv_data_valid),
    .o_wt_loaded        (o_wt_loaded),
    .o_line_done        (o_line_done)
  );

  int n_cmp = 0;
  int n_err = 0;
  int n_ld  = 0;
  int n_vld = 0;

  int pix [9];
  int m_shadow [9];
  int m_active [9];
  int m_idx;
  bit m_loaded;
  bit p_v [3];
  int p_d [3];
  int m_last;
  int m_nvalid;
  bit m_ld_next;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int ref_conv(input bit relu);
    longint s;
    longint q;
    s = 0;
    for (int k = 0; k < 9; k++)
      s += longint'(pix[k]) * longint'(m_active[k]);
    q = s / 16;
    if (s < 0 && (s % 16) != 0)
      q = q - 1;
    if (relu && q < 0) return 0;
    if (q > 4095) return 4095;
    if (q < -4096) return -4096;
    return int'(q);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 9; k++) begin
      m_shadow[k] = 0;
      m_active[k] = 0;
    end
    for (int k = 0; k < 3; k++) begin
      p_v[k] = 0;
      p_d[k] = 0;
    end
    m_idx = 0; m_loaded = 0; m_last = 0;
    m_nvalid = 0; m_ld_next = 0;
  endtask

  task automatic step();
    bit nv;
    int nd;
    bit exp_ld;
    for (int k = 0; k < 9; k++)
      i_pixel_data[W*k +: W] = W'(pix[k]);
    nv = i_pixel_data_valid && !i_rst;
    nd = nv ? ref_conv(i_relu_en) : 0;
    if (i_rst) begin
      model_reset();
    end else if (i_wt_valid) begin
      m_shadow[m_idx] = int'($signed(i_wt_data));
      if (m_idx == 8) begin
        m_active = m_shadow;
        m_loaded = 1;
        m_idx = 0;
      end else begin
        m_idx++;
      end
    end
    @(posedge clk);
    #1;
    if (!i_rst) begin
      p_v[2] = p_v[1]; p_d[2] = p_d[1];
      p_v[1] = p_v[0]; p_d[1] = p_d[0];
      p_v[0] = nv;     p_d[0] = nd;
    end
    exp_ld = m_ld_next;
    m_ld_next = 0;
    if (p_v[2]) begin
      m_last = p_d[2];
      m_nvalid++;
      m_ld_next = (m_nvalid % 512) == 0;
    end
    chk("valid", int'(o_conv_data_valid), int'(p_v[2]));
    chk("data", int'($signed(o_conv_data)), m_last);
    chk("wt_loaded", int'(o_wt_loaded), int'(m_loaded));
    chk("line_done", int'(o_line_done), int'(exp_ld));
    n_ld  += int'(o_line_done);
    n_vld += int'(o_conv_data_valid);
  endtask

  task automatic idle(input int n);
    i_pixel_data_valid = 0;
    i_wt_valid = 0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    i_rst = 1; i_pixel_data_valid = 0; i_wt_valid = 0;
    step();
    i_rst = 0;
  endtask

  task automatic load_wts(input int w [9]);
    for (int k = 0; k < 9; k++) begin
      i_wt_valid = 1;
      i_wt_data = W'(w[k]);
      step();
    end
    i_wt_valid = 0;
  endtask

  // One window then two idle cycles: output lands after the 3rd edge.
  task automatic win3(input int p [9], input bit relu);
    pix = p;
    i_pixel_data_valid = 1;
    i_relu_en = relu;
    step();
    i_pixel_data_valid = 0;
    step();
    step();
  endtask

  task automatic rand_pix(input int lim);
    for (int k = 0; k < 9; k++)
      pix[k] = int'($urandom_range(0, 2*lim)) - lim;
  endtask

  int w [9];
  int p [9];

  initial begin
    i_rst = 1; i_pixel_data_valid = 0; i_wt_valid = 0;
    i_wt_data = '0; i_relu_en = 0; i_pixel_data = '0;
    for (int k = 0; k < 9; k++) pix[k] = 0;
    model_reset();
    step(); step();
    i_rst = 0;
    step();
    chk("rst_data", int'(o_conv_data), 0);
    chk("rst_loaded", int'(o_wt_loaded), 0);

    // unloaded weights still yield a valid zero
    rand_pix(4000);
    p = pix;
    win3(p, 0);
    chk("zero_wt_valid", int'(o_conv_data_valid), 1);
    chk("zero_wt_data", int'($signed(o_conv_data)), 0);

    w = '{0, 0, 0, 0, 16, 0, 0, 0, 0};
    load_wts(w);
    p = '{500, 500, 500, 500, 163, 500, 500, 500, 500};
    win3(p, 0);
    chk("ident", int'($signed(o_conv_data)), 163);
    chk("ident_loaded", int'(o_wt_loaded), 1);

    w = '{16, 16, 16, 16, 16, 16, 16, 16, 16};
    load_wts(w);
    p = '{4095, 4095, 4095, 4095, 4095, 4095, 4095, 4095, 4095};
    win3(p, 0);
    chk("sat_pos", int'($signed(o_conv_data)), 4095);
    p = '{-4096, -4096, -4096, -4096, -4096, -4096, -4096, -4096, -4096};
    win3(p, 0);
    chk("sat_neg", int'($signed(o_conv_data)), -4096);
    win3(p, 1);
    chk("relu", int'($signed(o_conv_data)), 0);

    w = '{1, 0, 0, 0, 0, 0, 0, 0, 0};
    load_wts(w);
    p = '{-1, 0, 0, 0, 0, 0, 0, 0, 0};
    win3(p, 0);
    chk("floor_neg", int'($signed(o_conv_data)), -1);
    p = '{1, 0, 0, 0, 0, 0, 0, 0, 0};
    win3(p, 0);
    chk("floor_pos", int'($signed(o_conv_data)), 0);

    // 512-window stream with a reload overlapping the middle
    do_reset();
    for (int k = 0; k < 9; k++) w[k] = int'($urandom_range(0, 80)) - 40;
    load_wts(w);
    n_ld = 0; n_vld = 0;
    for (int i = 0; i < 512; i++) begin
      rand_pix(($urandom_range(0, 3) == 0) ? 4096 : 300);
      i_pixel_data_valid = 1;
      i_relu_en = 1'($urandom_range(0, 1));
      i_wt_valid = (i >= 200 && i < 209);
      i_wt_data = W'(int'($urandom_range(0, 80)) - 40);
      step();
    end
    idle(5);
    chk("stream_count", n_vld, 512);
    chk("stream_ld", n_ld, 1);

    // partial load discarded by reset
    for (int k = 0; k < 9; k++) w[k] = int'($urandom_range(1, 30));
    i_wt_valid = 1;
    for (int k = 0; k < 5; k++) begin
      i_wt_data = W'(w[k]);
      step();
    end
    i_wt_valid = 0;
    do_reset();
    chk("partial_loaded", int'(o_wt_loaded), 0);
    rand_pix(300);
    p = pix;
    win3(p, 0);
    chk("partial_zero", int'($signed(o_conv_data)), 0);
    load_wts(w);
    chk("reload_loaded", int'(o_wt_loaded), 1);
    for (int j = 0; j < 4; j++) begin
      rand_pix(300);
      p = pix;
      win3(p, 0);
    end

    // three windows in flight then reset
    for (int i = 0; i < 3; i++) begin
      rand_pix(300);
      i_pixel_data_valid = 1;
      step();
    end
    do_reset();
    n_vld = 0;
    idle(4);
    chk("flush_valid", n_vld, 0);
    rand_pix(300);
    p = pix;
    win3(p, 0);
    chk("after_flush", int'(o_conv_data_valid), 1);
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/conv3x3_mac.md
CONV3X3_MAC -- requirements
Module: conv3x3_mac

Interface
REQ-001 Parameter INTEGER_BITS, default 9, integer bits of each signed fixed-point word.
REQ-002 Parameter FIXED_POINT_BITS, default 4, fractional bits; word width W = INTEGER_BITS+FIXED_POINT_BITS (13).
REQ-003 i_clk  input  1  single clock; all state updates on rising edge.
REQ-004 i_rst  input  1  synchronous, active-high reset.
REQ-005 i_pixel_data  input  9*W  3x3 window; pixel k (0..8) at bits [W*k+W-1 : W*k], two's complement Q(INTEGER_BITS.FIXED_POINT_BITS).
REQ-006 i_pixel_data_valid  input  1  window valid this cycle; no backpressure.
REQ-007 i_wt_data  input  W  kernel weight word, same signed format as pixels.
REQ-008 i_wt_valid  input  1  write strobe for i_wt_data.
REQ-009 i_relu_en  input  1  clamp negative results to 0 when high; sampled with the pixel in stage 1.
REQ-010 o_conv_data  output  W  convolution result, signed Q format as inputs.
REQ-011 o_conv_data_valid  output  1  o_conv_data valid this cycle.
REQ-012 o_wt_loaded  output  1  high once a full 9-weight set has been committed.
REQ-013 o_line_done  output  1  one-cycle pulse after every 512th valid output.

Function
REQ-014 Weight load: 4-bit index counter 0..8; each i_wt_valid writes i_wt_data to shadow[index], index increments, wraps 8 -> 0.
REQ-015 On the cycle the write lands in shadow[8], all 9 shadow words (including the new one) copy into active weights at that same edge; o_wt_loaded goes 1 at that edge and stays 1 until reset.
REQ-016 Partial loads never affect active weights; windows in flight keep the active set sampled in stage 1.
REQ-017 Stage 1: register 9 signed products pixel[k]*active_w[k], each 2W bits (26), plus valid and relu_en.
REQ-018 Stage 2: register signed sum of the 9 products, 2W+4 bits (30), no overflow possible.
REQ-019 Stage 3: arithmetic shift right by FIXED_POINT_BITS (floor toward -inf); if relu_en and negative -> 0; else saturate to [-2^(W-1), 2^(W-1)-1] (-4096..4095); register to o_conv_data.
REQ-020 Latency exactly 3 cycles valid-in to o_conv_data_valid; full throughput, one window per cycle, back-to-back accepted.
REQ-021 o_conv_data holds its last value when o_conv_data_valid is 0.
REQ-022 Windows are processed regardless of o_wt_loaded; with unloaded weights (0) result is 0 and still flagged valid.
REQ-023 Output counter 9 bits counts o_conv_data_valid; when it is 511 and valid is high, it wraps to 0 and o_line_done pulses high the next cycle for one cycle.
REQ-024 Simultaneous i_wt_valid and i_pixel_data_valid: pixel uses active weights before the edge (new commit visible from the next window).

Reset
REQ-025 On i_rst: o_conv_data=0, o_conv_data_valid=0, o_wt_loaded=0, o_line_done=0, all pipeline valids 0, shadow and active weights 0, weight index 0, output counter 0.
REQ-026 Reset mid-operation discards all in-flight windows; no valid output appears for 3 cycles after reset deassertion unless new windows arrive.

Verification
REQ-027 Identity kernel: load w4=16, others 0; window pixel4=163, others 500 -> o_conv_data=163 exactly 3 cycles later, o_wt_loaded=1.
REQ-028 Saturation: all weights 16, all pixels 4095 -> 4095; all pixels -4096 with relu_en=0 -> -4096; relu_en=1 -> 0.
REQ-029 Floor rounding: w0=1, pixel0=-1, others 0 -> -1; pixel0=+1 -> 0.
REQ-030 Weight swap mid-stream: 512 back-to-back windows, reload 9 weights during stream -> outputs switch on the window sampled after the 9th write edge, none dropped, o_line_done pulses once after output 512.
REQ-031 Partial load: write 5 weights then reset -> o_wt_loaded=0, outputs use zero weights, next load starts at index 0.
REQ-032 Reset with 3 windows in flight -> no o_conv_data_valid after reset, output counter restarts at 0.
